// File: rtl/prof_pkg.sv
// Shared types and sizing helpers for the profiling event FIFO arbiter.
// Sizing functions are used in parameter port lists, so they must stay constant-evaluable.
package prof_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Ceiling log2; returns 0 for values of 1 or less.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int id_width(input int num_req);
        return (clog2(num_req) < 1) ? 1 : clog2(num_req);
    endfunction

    function automatic int entry_width(input int num_req, input int data_width);
        return id_width(num_req) + data_width;
    endfunction

endpackage

// File: rtl/prof_fifo.sv
// Show-ahead FIFO: the head entry is readable combinationally while not empty.
// Pointers and count clear on the first clock edge seen with rst_n low.
module prof_fifo
    import prof_pkg::*;
#(
    parameter int SIZE       = 16,
    parameter int DATA_WIDTH = 34,
    localparam int AW        = (clog2(SIZE) < 1) ? 1 : clog2(SIZE),
    localparam int CW        = clog2(SIZE) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enqueue,
    input  logic [DATA_WIDTH-1:0] back,
    input  logic                  dequeue,
    output logic [DATA_WIDTH-1:0] front,
    output logic                  empty,
    output logic                  full
);

    logic [DATA_WIDTH-1:0] mem [SIZE];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  do_enq;
    logic                  do_deq;

    assign empty  = (count_reg == '0);
    assign full   = (count_reg == CW'(SIZE));
    assign do_enq = enqueue && !full;
    assign do_deq = dequeue && !empty;
    assign front  = mem[rd_ptr_reg];

    // SIZE need not be a power of two, so pointers wrap explicitly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr_reg <= (wr_ptr_reg == AW'(SIZE - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_deq) begin
                rd_ptr_reg <= (rd_ptr_reg == AW'(SIZE - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(do_enq) - CW'(do_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[wr_ptr_reg] <= back;
        end
    end

endmodule

// File: rtl/prof_rr_arbiter.sv
// Round-robin one-hot arbiter; the search starts at rr_ptr and the pointer
// moves to one past the winner whenever a grant is issued.
module prof_rr_arbiter
    import prof_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW    = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               grant_valid
);

    logic [IDW-1:0] rr_ptr_reg;
    logic [IDW-1:0] rr_ptr_next;
    logic [IDW-1:0] cand_idx [NUM_REQ];
    logic           win_found;

    // One extra bit holds rr_ptr + offset (at most 2*NUM_REQ-2) before the modulo.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        logic [IDW:0] sum;
        assign sum = {1'b0, rr_ptr_reg} + (IDW + 1)'(gi);
        assign cand_idx[gi] = (sum >= (IDW + 1)'(NUM_REQ)) ?
                              IDW'(sum - (IDW + 1)'(NUM_REQ)) : sum[IDW-1:0];
    end

    always_comb begin
        win_found = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_valid[cand_idx[k]]) begin
                win_found = 1'b1;
                grant_idx = cand_idx[k];
            end
        end
        grant_valid = win_found && enable;
        grant       = '0;
        rr_ptr_next = rr_ptr_reg;
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
            rr_ptr_next      = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/prof_fifo_arbiter.sv
// Shares one event FIFO among NUM_REQ profiling sources: round-robin enqueue,
// valid/ready drain and a flush sequencer, plus a high-water occupancy monitor.
module prof_fifo_arbiter
    import prof_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_SIZE  = 16,
    localparam int IDW       = id_width(NUM_REQ),
    localparam int EW        = entry_width(NUM_REQ, DATA_WIDTH),
    localparam int HWW       = clog2(FIFO_SIZE) + 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            reqValid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]            reqReady,
    output logic                          outValid,
    output logic [EW-1:0]                 outData,
    input  logic                          outReady,
    input  logic                          flush,
    output logic                          flushDone,
    output logic                          busy,
    output logic [HWW-1:0]                highWater
);

    state_t          state_reg;
    state_t          state_next;
    logic [HWW-1:0]  occ_reg;
    logic [HWW-1:0]  occ_next;
    logic [HWW-1:0]  high_water_reg;
    logic [HWW-1:0]  high_water_next;
    logic            fifo_empty;
    logic            fifo_full;
    logic            fifo_deq;
    logic [EW-1:0]   fifo_front;
    logic [EW-1:0]   fifo_back;
    logic            arb_enable;
    logic [IDW-1:0]  grant_idx;
    logic            grant_valid;

    // rst_n gates the enables so outputs drop immediately, before the FIFO's edge-timed clear.
    assign arb_enable = rst_n && (state_reg == ST_RUN) && !flush && !fifo_full;
    assign fifo_back  = {grant_idx, reqData[grant_idx*DATA_WIDTH +: DATA_WIDTH]};

    prof_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (reqValid),
        .enable      (arb_enable),
        .grant       (reqReady),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    prof_fifo #(
        .SIZE       (FIFO_SIZE),
        .DATA_WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .enqueue (grant_valid),
        .back    (fifo_back),
        .dequeue (fifo_deq),
        .front   (fifo_front),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_comb begin
        state_next = state_reg;
        outValid   = 1'b0;
        fifo_deq   = 1'b0;
        flushDone  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            ST_RUN: begin
                outValid = rst_n && !fifo_empty;
                fifo_deq = outValid && outReady;
                if (flush) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy     = 1'b1;
                fifo_deq = !fifo_empty;
                if (fifo_empty) begin
                    flushDone  = 1'b1;
                    state_next = ST_RUN;
                end
            end
        endcase
    end

    assign outData = outValid ? fifo_front : '0;

    // Occupancy mirror counts only the commits the FIFO will actually perform.
    assign occ_next        = occ_reg + HWW'(grant_valid) - HWW'(fifo_deq && !fifo_empty);
    assign high_water_next = (occ_next > high_water_reg) ? occ_next : high_water_reg;
    assign highWater       = high_water_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_RUN;
            occ_reg        <= '0;
            high_water_reg <= '0;
        end else begin
            state_reg      <= state_next;
            occ_reg        <= occ_next;
            high_water_reg <= high_water_next;
        end
    end

endmodule

// File: tb/tb_prof_fifo_arbiter.sv
// Bench for prof_fifo_arbiter: vector table, directed corner sequences and a
// random run, all checked against a queue-based model of the arbiter.
module tb_prof_fifo_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int FS  = 16;
    localparam int EW  = 34;
    localparam int HWW = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    reqValid = '0;
    logic [NR*DW-1:0] reqData = '0;
    logic [NR-1:0]    reqReady;
    logic             outValid;
    logic [EW-1:0]    outData;
    logic             outReady = 1'b0;
    logic             flush = 1'b0;
    logic             flushDone;
    logic             busy;
    logic [HWW-1:0]   highWater;

    int n_tot = 0;
    int n_bad = 0;

    // Reference model state
    logic [EW-1:0] m_q[$];
    int            m_rr;
    bit            m_fl;
    int            m_hw;
    int            m_win;

    typedef struct {
        logic [NR-1:0]  req_valid;
        logic           out_ready;
        logic [NR-1:0]  exp_ready;
        logic           exp_out_valid;
        logic [HWW-1:0] exp_hw;
    } vec_t;
    vec_t vecs [20];

    prof_fifo_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_SIZE(FS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reqValid  (reqValid),
        .reqData   (reqData),
        .reqReady  (reqReady),
        .outValid  (outValid),
        .outData   (outData),
        .outReady  (outReady),
        .flush     (flush),
        .flushDone (flushDone),
        .busy      (busy),
        .highWater (highWater)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rr = 0;
        m_fl = 1'b0;
        m_hw = 0;
        m_win = -1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        reqValid = '0;
        reqData = '0;
        outReady = 1'b0;
        flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called at posedge+1; samples at the falling edge and compares to the model.
    task automatic sample_and_check();
        logic [NR-1:0] er;
        logic ev, ed, eb;
        logic [EW-1:0] eo;
        int w;
        #4;
        er = '0; ev = 1'b0; eo = '0; ed = 1'b0; eb = 1'b0; w = -1;
        if (!m_fl) begin
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_rr + k) % NR;
                if (w < 0 && reqValid[i]) w = i;
            end
            if (w >= 0 && m_q.size() < FS && !flush) er[w] = 1'b1;
            else w = -1;
            ev = (m_q.size() != 0);
            if (ev) eo = m_q[0];
        end else begin
            eb = 1'b1;
            ed = (m_q.size() == 0);
        end
        chk("reqReady", 64'(reqReady), 64'(er));
        chk("outValid", 64'(outValid), 64'(ev));
        if (ev) chk("outData", 64'(outData), 64'(eo));
        chk("flushDone", 64'(flushDone), 64'(ed));
        chk("busy", 64'(busy), 64'(eb));
        chk("highWater", 64'(highWater), 64'(m_hw));
        m_win = w;
    endtask

    task automatic advance();
        bit was_empty;
        bit deq;
        logic [1:0] wid;
        @(posedge clk);
        was_empty = (m_q.size() == 0);
        deq = m_fl ? !was_empty : (!was_empty && outReady);
        if (deq) void'(m_q.pop_front());
        if (m_win >= 0) begin
            wid = m_win[1:0];
            m_q.push_back({wid, reqData[m_win*DW +: DW]});
            m_rr = (m_win + 1) % NR;
        end
        if (m_fl) begin
            if (was_empty) m_fl = 1'b0;
        end else if (flush) begin
            m_fl = 1'b1;
        end
        if (m_q.size() > m_hw) m_hw = m_q.size();
        #1;
    endtask

    task automatic tick();
        sample_and_check();
        advance();
    endtask

    initial begin
        for (int i = 0; i < 20; i++) begin
            vecs[i].req_valid     = 4'hF;
            vecs[i].out_ready     = 1'b0;
            vecs[i].exp_ready     = (i < 16) ? NR'(1 << (i % 4)) : '0;
            vecs[i].exp_out_valid = (i != 0);
            vecs[i].exp_hw        = HWW'((i < 16) ? i : 16);
        end

        // Reset state, then a lone requester 2 (payload tagged with id 2)
        reset_dut();
        sample_and_check();
        chk("rst_reqReady", 64'(reqReady), 64'h0);
        chk("rst_outValid", 64'(outValid), 64'h0);
        chk("rst_highWater", 64'(highWater), 64'h0);
        advance();
        reqData = {32'h3333_3333, 32'hA5A5_0002, 32'h1111_1111, 32'h0000_0000};
        reqValid = 4'b0100;
        outReady = 1'b1;
        sample_and_check();
        chk("lone_grant", 64'(reqReady), 64'h4);
        advance();
        reqValid = '0;
        sample_and_check();
        chk("lone_outValid", 64'(outValid), 64'h1);
        chk("lone_outData", 64'(outData), 64'h2_A5A5_0002);
        advance();
        reqValid = 4'hF;
        sample_and_check();
        chk("rr_after_2", 64'(reqReady), 64'h8);
        reqValid = '0;
        advance();

        // Fill from reset with all requesters active and no draining
        reset_dut();
        for (int i = 0; i < 20; i++) begin
            reqValid = vecs[i].req_valid;
            outReady = vecs[i].out_ready;
            reqData = {$urandom(), $urandom(), $urandom(), $urandom()};
            sample_and_check();
            chk($sformatf("vec%0d_ready", i), 64'(reqReady), 64'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_outValid", i), 64'(outValid), 64'(vecs[i].exp_out_valid));
            chk($sformatf("vec%0d_hw", i), 64'(highWater), 64'(vecs[i].exp_hw));
            advance();
        end

        // Full FIFO: dequeue first, enqueue one cycle later
        reqValid = 4'b0001;
        outReady = 1'b1;
        sample_and_check();
        chk("full_block", 64'(reqReady), 64'h0);
        chk("full_outValid", 64'(outValid), 64'h1);
        advance();
        sample_and_check();
        chk("full_then_grant", 64'(reqReady), 64'h1);
        chk("full_hw", 64'(highWater), 64'd16);
        advance();
        reqValid = '0;
        outReady = 1'b0;

        // Flush with eight entries queued
        reset_dut();
        reqValid = 4'hF;
        for (int i = 0; i < 8; i++) tick();
        reqValid = '0;
        flush = 1'b1;
        sample_and_check();
        chk("flush_start_busy", 64'(busy), 64'h0);
        advance();
        flush = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            sample_and_check();
            chk($sformatf("flush%0d_busy", c), 64'(busy), 64'h1);
            chk($sformatf("flush%0d_done", c), 64'(flushDone), 64'h0);
            advance();
        end
        sample_and_check();
        chk("flush9_done", 64'(flushDone), 64'h1);
        advance();
        sample_and_check();
        chk("flush10_done", 64'(flushDone), 64'h0);
        chk("flush10_busy", 64'(busy), 64'h0);
        chk("flush10_outValid", 64'(outValid), 64'h0);
        advance();

        // Flush and request in the same cycle on an empty FIFO
        reqValid = 4'b0010;
        flush = 1'b1;
        sample_and_check();
        chk("flushreq_nogrant", 64'(reqReady), 64'h0);
        advance();
        flush = 1'b0;
        sample_and_check();
        chk("flushreq_done", 64'(flushDone), 64'h1);
        chk("flushreq_ready", 64'(reqReady), 64'h0);
        advance();
        sample_and_check();
        chk("flushreq_grant", 64'(reqReady), 64'h2);
        advance();
        reqValid = '0;

        // Reset asserted mid-flush with five entries queued
        reqValid = 4'hF;
        for (int i = 0; i < 4; i++) tick();
        reqValid = '0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        reqValid = 4'hF;
        #1;
        chk("arst_reqReady", 64'(reqReady), 64'h0);
        chk("arst_outValid", 64'(outValid), 64'h0);
        chk("arst_outData", 64'(outData), 64'h0);
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_flushDone", 64'(flushDone), 64'h0);
        chk("arst_highWater", 64'(highWater), 64'h0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        reqValid = '0;
        sample_and_check();
        chk("arst_release_empty", 64'(outValid), 64'h0);
        chk("arst_release_hw", 64'(highWater), 64'h0);
        advance();

        // Random traffic with drain rate varying per block
        for (int c = 0; c < 3000; c++) begin
            int p;
            p = (c / 200) % 3;
            reqValid = NR'($urandom());
            reqData = {$urandom(), $urandom(), $urandom(), $urandom()};
            outReady = (($urandom() % 4) < ((p == 0) ? 1 : (p == 1) ? 3 : 4));
            flush = (($urandom() % 64) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
